// File: rtl/jt12_reg_chx.sv
// Channel register file for the JT12 FM core: per-channel frequency, algorithm
// and stereo/LFO parameters, channel-3 special frequencies and a CPU readback port.
module jt12_reg_chx #(
    parameter int NUM_CH  = 6,
    parameter int SPECIAL = 1,
    parameter int AMS_LAG = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [7:0]  din,
    input  logic [2:0]  up_ch,
    input  logic        up_fnumhi,
    input  logic        up_fnumlo,
    input  logic        up_fnumhi3,
    input  logic        up_fnumlo3,
    input  logic [1:0]  up_op3,
    input  logic        up_alg,
    input  logic        up_pms,
    input  logic        ch3_mode,
    input  logic [2:0]  ch,
    input  logic [1:0]  op,
    output logic [2:0]  block,
    output logic [10:0] fnum,
    output logic [2:0]  fb,
    output logic [2:0]  alg,
    output logic [1:0]  rl,
    output logic [1:0]  ams,
    output logic [2:0]  pms,
    input  logic [2:0]  rd_ch,
    input  logic [1:0]  rd_sel,
    output logic [7:0]  rd_data
);

    localparam logic [2:0] LAG = 3'(AMS_LAG % 8);

    function automatic logic f_valid(input logic [2:0] c);
        return (c[1:0] != 2'd3) && (NUM_CH == 6 || !c[2]);
    endfunction

    function automatic logic [2:0] f_idx(input logic [2:0] c);
        return c[2] ? 3'd3 + {1'b0, c[1:0]} : {1'b0, c[1:0]};
    endfunction

    logic [2:0]  r_block  [0:5];
    logic [10:0] r_fnum   [0:5];
    logic [2:0]  r_fb     [0:5];
    logic [2:0]  r_alg    [0:5];
    logic [1:0]  r_rl     [0:5];
    logic [1:0]  r_ams    [0:5];
    logic [2:0]  r_pms    [0:5];
    logic [2:0]  r_sblock [0:2];
    logic [10:0] r_sfnum  [0:2];
    logic [5:0]  r_latch;
    logic [5:0]  r_latch3;

    logic        w_up_ok;
    logic [2:0]  w_up_idx;
    logic        w_ok;
    logic [2:0]  w_idx;
    logic [2:0]  w_ach;
    logic        w_aok;
    logic [2:0]  w_aidx;
    logic        w_spec;
    logic        w_rok;
    logic [2:0]  w_ridx;

    assign w_up_ok  = f_valid(up_ch);
    assign w_up_idx = f_idx(up_ch);
    assign w_ok     = f_valid(ch);
    assign w_idx    = f_idx(ch);
    assign w_ach    = ch - LAG;
    assign w_aok    = f_valid(w_ach);
    assign w_aidx   = f_idx(w_ach);
    assign w_rok    = f_valid(rd_ch);
    assign w_ridx   = f_idx(rd_ch);
    assign w_spec   = (SPECIAL != 0) && ch3_mode && (ch == 3'd2) && (op != 2'd3);

    // Commits read the latch before this edge's hi write replaces it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_latch  <= '0;
            r_latch3 <= '0;
            for (int i = 0; i < 6; i++) begin
                r_block[i] <= '0;
                r_fnum[i]  <= '0;
                r_fb[i]    <= '0;
                r_alg[i]   <= '0;
                r_rl[i]    <= 2'b11;
                r_ams[i]   <= '0;
                r_pms[i]   <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                r_sblock[i] <= '0;
                r_sfnum[i]  <= '0;
            end
        end else begin
            if (up_fnumhi)
                r_latch <= din[5:0];
            if (up_fnumlo && w_up_ok) begin
                r_block[w_up_idx] <= r_latch[5:3];
                r_fnum[w_up_idx]  <= {r_latch[2:0], din};
            end
            if (up_alg && w_up_ok) begin
                r_fb[w_up_idx]  <= din[5:3];
                r_alg[w_up_idx] <= din[2:0];
            end
            if (up_pms && w_up_ok) begin
                r_rl[w_up_idx]  <= din[7:6];
                r_ams[w_up_idx] <= din[5:4];
                r_pms[w_up_idx] <= din[2:0];
            end
            if (SPECIAL != 0) begin
                if (up_fnumhi3)
                    r_latch3 <= din[5:0];
                if (up_fnumlo3 && up_op3 != 2'd3) begin
                    r_sblock[up_op3] <= r_latch3[5:3];
                    r_sfnum[up_op3]  <= {r_latch3[2:0], din};
                end
            end
        end
    end

    logic [2:0]  w_nblock;
    logic [10:0] w_nfnum;
    logic [2:0]  w_nfb;
    logic [2:0]  w_nalg;
    logic [1:0]  w_nrl;
    logic [1:0]  w_nams;
    logic [2:0]  w_npms;

    always_comb begin
        w_nblock = '0;
        w_nfnum  = '0;
        w_nfb    = '0;
        w_nalg   = '0;
        w_nrl    = 2'b11;
        w_nams   = '0;
        w_npms   = '0;
        if (w_ok) begin
            w_nblock = r_block[w_idx];
            w_nfnum  = r_fnum[w_idx];
            w_nfb    = r_fb[w_idx];
            w_nalg   = r_alg[w_idx];
            w_nrl    = (NUM_CH == 3) ? 2'b11 : r_rl[w_idx];
            w_npms   = r_pms[w_idx];
        end
        if (w_spec) begin
            w_nblock = r_sblock[op];
            w_nfnum  = r_sfnum[op];
        end
        if (w_aok)
            w_nams = r_ams[w_aidx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            block <= '0;
            fnum  <= '0;
            fb    <= '0;
            alg   <= '0;
            rl    <= 2'b11;
            ams   <= '0;
            pms   <= '0;
        end else if (cen) begin
            block <= w_nblock;
            fnum  <= w_nfnum;
            fb    <= w_nfb;
            alg   <= w_nalg;
            rl    <= w_nrl;
            ams   <= w_nams;
            pms   <= w_npms;
        end
    end

    // Readback ignores ch3_mode; invalid codes read as reset values
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (!w_rok) begin
            rd_data <= (rd_sel == 2'd3) ? 8'hC0 : 8'h00;
        end else begin
            unique case (rd_sel)
                2'd0: rd_data <= r_fnum[w_ridx][7:0];
                2'd1: rd_data <= {2'b0, r_block[w_ridx], r_fnum[w_ridx][10:8]};
                2'd2: rd_data <= {2'b0, r_fb[w_ridx], r_alg[w_ridx]};
                2'd3: rd_data <= {r_rl[w_ridx], r_ams[w_ridx], 1'b0, r_pms[w_ridx]};
                default: rd_data <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_jt12_reg_chx.sv
// Bench for jt12_reg_chx: 6- and 3-channel builds driven side by side and
// compared against a channel-code-indexed reference model.
module tb_jt12_reg_chx;

    logic        clk = 0;
    logic        rst = 1, cen = 0;
    logic [7:0]  din = 0;
    logic [2:0]  up_ch = 0;
    logic        up_fnumhi = 0, up_fnumlo = 0, up_fnumhi3 = 0, up_fnumlo3 = 0;
    logic [1:0]  up_op3 = 0;
    logic        up_alg = 0, up_pms = 0, ch3_mode = 0;
    logic [2:0]  ch = 0;
    logic [1:0]  op = 0;
    logic [2:0]  rd_ch = 0;
    logic [1:0]  rd_sel = 0;

    logic [2:0]  block6, fb6, alg6, pms6, block3, fb3, alg3, pms3;
    logic [10:0] fnum6, fnum3;
    logic [1:0]  rl6, ams6, rl3, ams3;
    logic [7:0]  rd6, rd3;

    always #5 clk = ~clk;

    jt12_reg_chx #(.NUM_CH(6), .SPECIAL(1), .AMS_LAG(4)) dut6 (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .up_ch(up_ch),
        .up_fnumhi(up_fnumhi), .up_fnumlo(up_fnumlo),
        .up_fnumhi3(up_fnumhi3), .up_fnumlo3(up_fnumlo3), .up_op3(up_op3),
        .up_alg(up_alg), .up_pms(up_pms), .ch3_mode(ch3_mode),
        .ch(ch), .op(op), .block(block6), .fnum(fnum6), .fb(fb6),
        .alg(alg6), .rl(rl6), .ams(ams6), .pms(pms6),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd6));

    jt12_reg_chx #(.NUM_CH(3), .SPECIAL(1), .AMS_LAG(4)) dut3 (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .up_ch(up_ch),
        .up_fnumhi(up_fnumhi), .up_fnumlo(up_fnumlo),
        .up_fnumhi3(up_fnumhi3), .up_fnumlo3(up_fnumlo3), .up_op3(up_op3),
        .up_alg(up_alg), .up_pms(up_pms), .ch3_mode(ch3_mode),
        .ch(ch), .op(op), .block(block3), .fnum(fnum3), .fb(fb3),
        .alg(alg3), .rl(rl3), .ams(ams3), .pms(pms3),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd3));

    logic [26:0] o6, o3;
    assign o6 = {block6, fnum6, fb6, alg6, rl6, ams6, pms6};
    assign o3 = {block3, fnum3, fb3, alg3, rl3, ams3, pms3};

    localparam logic [26:0] RST_OUT = {3'd0, 11'd0, 3'd0, 3'd0, 2'd3, 2'd0, 3'd0};

    // Model: storage per channel code, [0]=6-ch build, [1]=3-ch build
    logic [2:0]  m_blk [2][8];
    logic [10:0] m_fn  [2][8];
    logic [2:0]  m_fb  [2][8];
    logic [2:0]  m_alg [2][8];
    logic [1:0]  m_rl  [2][8];
    logic [1:0]  m_ams [2][8];
    logic [2:0]  m_pms [2][8];
    logic [2:0]  m_sblk [3];
    logic [10:0] m_sfn  [3];
    logic [5:0]  m_lat, m_lat3;
    logic [26:0] e_out [2];
    logic [7:0]  e_rd  [2];

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 8; c++) begin
                m_blk[k][c] = 0; m_fn[k][c] = 0; m_fb[k][c] = 0; m_alg[k][c] = 0;
                m_rl[k][c] = 3; m_ams[k][c] = 0; m_pms[k][c] = 0;
            end
        for (int s = 0; s < 3; s++) begin
            m_sblk[s] = 0; m_sfn[s] = 0;
        end
        m_lat = 0; m_lat3 = 0;
    endtask

    function automatic bit legal(input int k, input logic [2:0] c);
        return c[1:0] != 2'd3 && (k == 0 || c[2] == 1'b0);
    endfunction

    function automatic logic [26:0] model_out(input int k);
        int c, a;
        logic [2:0] b;
        logic [10:0] f;
        logic [1:0] r;
        c = int'(ch);
        a = (c - 4 + 8) % 8;
        b = m_blk[k][c];
        f = m_fn[k][c];
        if (ch3_mode && c == 2 && op < 3) begin
            b = m_sblk[op];
            f = m_sfn[op];
        end
        r = (k == 1) ? 2'd3 : m_rl[k][c];
        return {b, f, m_fb[k][c], m_alg[k][c], r, m_ams[k][a], m_pms[k][c]};
    endfunction

    function automatic logic [7:0] model_rd(input int k);
        int c;
        c = int'(rd_ch);
        case (rd_sel)
            0: return m_fn[k][c][7:0];
            1: return {2'b0, m_blk[k][c], m_fn[k][c][10:8]};
            2: return {2'b0, m_fb[k][c], m_alg[k][c]};
            default: return {m_rl[k][c], m_ams[k][c], 1'b0, m_pms[k][c]};
        endcase
    endfunction

    task automatic model_write();
        int c;
        c = int'(up_ch);
        for (int k = 0; k < 2; k++) begin
            if (!legal(k, up_ch)) continue;
            if (up_fnumlo) begin
                m_blk[k][c] = m_lat[5:3];
                m_fn[k][c] = {m_lat[2:0], din};
            end
            if (up_alg) begin
                m_fb[k][c] = din[5:3];
                m_alg[k][c] = din[2:0];
            end
            if (up_pms) begin
                m_rl[k][c] = din[7:6];
                m_ams[k][c] = din[5:4];
                m_pms[k][c] = din[2:0];
            end
        end
        if (up_fnumlo3 && up_op3 != 3) begin
            m_sblk[up_op3] = m_lat3[5:3];
            m_sfn[up_op3] = {m_lat3[2:0], din};
        end
        if (up_fnumhi) m_lat = din[5:0];
        if (up_fnumhi3) m_lat3 = din[5:0];
    endtask

    task automatic step();
        logic [26:0] no [2];
        logic [7:0]  nr [2];
        for (int k = 0; k < 2; k++) begin
            no[k] = cen ? model_out(k) : e_out[k];
            nr[k] = model_rd(k);
        end
        if (rst) begin
            model_reset();
            no[0] = RST_OUT; no[1] = RST_OUT;
            nr[0] = 0; nr[1] = 0;
        end else begin
            model_write();
        end
        e_out[0] = no[0]; e_out[1] = no[1];
        e_rd[0] = nr[0]; e_rd[1] = nr[1];
        @(posedge clk);
        #1;
        chk("out6", {5'd0, o6}, {5'd0, e_out[0]});
        chk("out3", {5'd0, o3}, {5'd0, e_out[1]});
        chk("rd6", {24'd0, rd6}, {24'd0, e_rd[0]});
        chk("rd3", {24'd0, rd3}, {24'd0, e_rd[1]});
    endtask

    task automatic idle();
        up_fnumhi = 0; up_fnumlo = 0; up_fnumhi3 = 0; up_fnumlo3 = 0;
        up_alg = 0; up_pms = 0;
    endtask

    initial begin
        model_reset();
        e_out[0] = RST_OUT; e_out[1] = RST_OUT;
        e_rd[0] = 0; e_rd[1] = 0;
        #1;
        rst = 1; step(); step();
        rst = 0;

        ch = 5; cen = 1; step(); step();
        chk("rst_rl", {30'd0, rl6}, 3);
        rd_ch = 5; rd_sel = 3; step();
        chk("rst_rd", {24'd0, rd6}, 32'hC0);

        cen = 0;
        up_fnumhi = 1; din = 8'h2C; step(); idle();
        up_fnumlo = 1; up_ch = 4; din = 8'h5A; step(); idle();
        ch = 4; cen = 1; step();
        chk("blk_ch4", {29'd0, block6}, 5);
        chk("fn_ch4", {21'd0, fnum6}, 32'h45A);
        rd_ch = 4; rd_sel = 1; step();
        chk("rd_ch4", {24'd0, rd6}, 32'h2C);

        up_fnumhi = 1; din = 8'h10; step();
        up_fnumlo = 1; up_ch = 0; din = 8'h3F; step(); idle();
        ch = 0; step();
        chk("same_fn", {21'd0, fnum6}, 32'h03F);
        chk("same_blk", {29'd0, block6}, 2);
        up_fnumlo = 1; din = 8'h22; step(); idle(); step();
        chk("reuse_fn", {21'd0, fnum6}, 32'h722);
        chk("reuse_blk", {29'd0, block6}, 7);

        up_fnumhi = 1; up_ch = 2; din = 8'h09; step(); idle();
        up_fnumlo = 1; din = 8'h44; step(); idle();
        up_fnumhi3 = 1; din = 8'h19; step(); idle();
        up_fnumlo3 = 1; up_op3 = 1; din = 8'h23; step(); idle();
        ch3_mode = 1; ch = 2; op = 1; step();
        chk("sp_fn", {21'd0, fnum6}, 32'h123);
        chk("sp_blk", {29'd0, block6}, 3);
        op = 3; step();
        chk("sp_op3", {21'd0, fnum6}, 32'h144);
        ch3_mode = 0; op = 1; step();
        chk("sp_off", {21'd0, fnum6}, 32'h144);

        up_pms = 1; up_ch = 1; din = 8'h30; step(); idle();
        ch = 5; step();
        chk("ams_lag", {30'd0, ams6}, 3);
        ch = 1; step();
        chk("ams_own", {30'd0, ams6}, 0);
        up_alg = 1; up_ch = 3; din = 8'hFF; step();
        up_ch = 7; step(); idle();
        rd_ch = 3; rd_sel = 2; step();
        rd_ch = 7; step();

        up_pms = 1; up_ch = 0; din = 8'h00; step(); idle();
        ch = 0; rd_ch = 0; rd_sel = 3; step();
        chk("rl3_out", {30'd0, rl3}, 3);
        chk("rl3_rd", {24'd0, rd3}, 0);
        up_fnumlo = 1; up_ch = 4; din = 8'hAB; step(); idle();
        rd_ch = 4; rd_sel = 0; step();
        chk("ch4_3ch", {24'd0, rd3}, 0);

        cen = 0; rst = 1; up_alg = 1; up_ch = 1; din = 8'h3F; step();
        rst = 0; idle();
        chk("rst_mid", {5'd0, o6}, {5'd0, RST_OUT});

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(99) == 0);
            cen = $urandom_range(1);
            din = 8'($urandom);
            up_ch = 3'($urandom);
            up_fnumhi = ($urandom_range(2) == 0);
            up_fnumlo = ($urandom_range(2) == 0);
            up_fnumhi3 = ($urandom_range(2) == 0);
            up_fnumlo3 = ($urandom_range(2) == 0);
            up_op3 = 2'($urandom);
            up_alg = ($urandom_range(2) == 0);
            up_pms = ($urandom_range(2) == 0);
            ch3_mode = $urandom_range(1);
            ch = ($urandom_range(2) == 0) ? 3'd2 : 3'($urandom);
            op = 2'($urandom);
            rd_ch = 3'($urandom);
            rd_sel = 2'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
